uart_tx_streamer: RTL

- Serial UART transmitter stage directly downstream of the address/read sequencer that walks the 64K sample memory.
- Takes the byte on the memory read port, frames it (start, data LSB-first, optional even parity, stop) and drives the TX line.
- Issues a one-cycle tx_tick per completed frame; this pulse is what advances the sequencer's address.
- Inserts a read-latency holdoff so the next byte is sampled only after the memory output has settled for the new address.

---
 rtl/uart_tx_streamer_if.sv | 25 ++
 rtl/uart_tx_streamer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_streamer_if.sv
// Handshake bundle between the memory read sequencer and the UART transmit stage.
// The sequencer owns tx_en/tx_data; the transmitter owns the line and status.
interface uart_tx_streamer_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_tick;

  modport master (
    output tx_en,
    output tx_data,
    input  tx,
    input  tx_busy,
    input  tx_tick
  );

  modport slave (
    input  tx_en,
    input  tx_data,
    output tx,
    output tx_busy,
    output tx_tick
  );
endinterface

// File: rtl/uart_tx_streamer.sv
// UART transmitter fed straight from the sample memory read port.
// Frames one byte (start, data LSB-first, optional even parity, stop bits),
// pulses tx_tick once per finished frame to advance the sequencer address,
// then holds off long enough for the memory output to settle on the new address.
module uart_tx_streamer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1,
  parameter int RD_LATENCY   = 2
) (
  input logic              clk,
  input logic              rst,
  uart_tx_streamer_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int HOLD_W = $clog2(RD_LATENCY + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RD_LATENCY - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_next;
  logic              parity_bit;
  logic              parity_next;
  logic              tx_reg;
  logic              tx_next;
  logic              busy_reg;
  logic              busy_next;
  logic              tick_reg;
  logic              tick_next;
  logic [7:0]        data_word;
  logic              baud_done;

  // Upper bits beyond DATA_BITS are cleared so they never reach the line or the parity.
  assign data_word = bus.tx_data & DATA_MASK;
  assign baud_done = (baud_cnt == BAUD_LAST);

  assign bus.tx      = tx_reg;
  assign bus.tx_busy = busy_reg;
  assign bus.tx_tick = tick_reg;

  // Next-state and next-output logic; tx is computed for the state being entered
  // so that the registered line changes on the same edge as the state.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_idx;
    hold_next   = hold_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    tx_next     = tx_reg;
    tick_next   = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (bus.tx_en) begin
          shift_next  = data_word;
          parity_next = ^data_word;
          baud_next   = '0;
          bit_next    = '0;
          tx_next     = 1'b0;
          state_next  = START;
        end
      end

      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == DATA_LAST) begin
            bit_next = '0;
            if (PARITY_EN != 0) begin
              tx_next    = parity_bit;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      PARITY: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == STOP_LAST) begin
            bit_next   = '0;
            hold_next  = '0;
            tick_next  = 1'b1;
            state_next = HOLD;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      HOLD: begin
        tx_next = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          hold_next  = '0;
          state_next = IDLE;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State, counters and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      hold_cnt   <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      hold_cnt   <= hold_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      tick_reg   <= tick_next;
    end
  end

endmodule
